// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters,
// with a bounded burst hold and a tagged one-cycle read return.
//
// state | meaning
// IDLE  | no owner; next request (tie -> port after rr_last) is granted
// OWN0  | port 0 owns the memory, cnt counts its consecutive grants
// OWN1  | port 1 owns the memory, cnt counts its consecutive grants
module spram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 4096,
    parameter int MAX_BURST = 4,
    localparam int AW       = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [AW-1:0]    r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    input  logic [3:0]       r0_mask,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rdata,

    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [AW-1:0]    r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    input  logic [3:0]       r1_mask,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rdata,

    output logic             mem_wen,
    output logic             mem_ren,
    output logic [AW-1:0]    mem_waddr,
    output logic [AW-1:0]    mem_raddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_mask,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            rr_last, rr_last_nxt;
    logic            gnt0, gnt1;
    logic            rd_pend, rd_owner;
    logic            xfer, sel_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_last  <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rr_last <= rr_last_nxt;
            rd_pend <= mem_ren;
            if (mem_ren) begin
                rd_owner <= r1_gnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req && (!r1_req || rr_last)) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else if (r1_req) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWN0: begin
                if (r0_req && ((cnt < CNT_MAX) || !r1_req)) begin
                    gnt0    = 1'b1;
                    cnt_nxt = (cnt < CNT_MAX) ? cnt + CNT_ONE : CNT_MAX;
                end else if (r1_req) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            OWN1: begin
                if (r1_req && ((cnt < CNT_MAX) || !r0_req)) begin
                    gnt1    = 1'b1;
                    cnt_nxt = (cnt < CNT_MAX) ? cnt + CNT_ONE : CNT_MAX;
                end else if (r0_req) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Grants are masked while reset is asserted so nothing reaches the macro.
    assign r0_gnt = gnt0 & ~rst;
    assign r1_gnt = gnt1 & ~rst;

    always_comb begin
        rr_last_nxt = rr_last;
        if (r1_gnt) begin
            rr_last_nxt = 1'b1;
        end else if (r0_gnt) begin
            rr_last_nxt = 1'b0;
        end
    end

    assign xfer   = r0_gnt | r1_gnt;
    assign sel_we = r1_gnt ? r1_we : r0_we;

    always_comb begin
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (xfer) begin
            mem_wen   = sel_we;
            mem_ren   = ~sel_we;
            mem_waddr = r1_gnt ? r1_addr  : r0_addr;
            mem_raddr = r1_gnt ? r1_addr  : r0_addr;
            mem_wdata = r1_gnt ? r1_wdata : r0_wdata;
            mem_mask  = r1_gnt ? r1_mask  : r0_mask;
        end
    end

    assign r0_rvalid = rd_pend & ~rd_owner;
    assign r1_rvalid = rd_pend &  rd_owner;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: per-cycle vector table plus hand-written
// sequences for burst rotation, streaming reads and reset during a read.
module tb_spram_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [31:0]   r0_wdata, r1_wdata;
    logic [3:0]    r0_mask, r1_mask;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0]   r0_rdata, r1_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.WIDTH(32), .SIZE(4096), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_mask(r0_mask), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_mask(r1_mask), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    // SRAM model: byte-masked write, registered read; reloaded on reset.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[5]    <= 32'hA5A5_0001;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_wen)
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (mem_ren) mem_rdata <= mem[mem_raddr];
        end
    end

    typedef struct {
        logic q0; logic w0; logic [AW-1:0] a0; logic [31:0] d0; logic [3:0] m0;
        logic q1; logic w1; logic [AW-1:0] a1; logic [31:0] d1; logic [3:0] m1;
        logic e_g0; logic e_g1; logic e_wen; logic e_ren; logic [AW-1:0] e_addr;
        logic [31:0] e_wdata; logic [3:0] e_mask;
        logic e_rv0; logic e_rv1; logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_mask = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_mask = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_mem_idle(input string tag);
        check({tag, "_wen"},   32'(mem_wen),   32'h0);
        check({tag, "_ren"},   32'(mem_ren),   32'h0);
        check({tag, "_waddr"}, 32'(mem_waddr), 32'h0);
        check({tag, "_raddr"}, 32'(mem_raddr), 32'h0);
        check({tag, "_wdata"}, mem_wdata,      32'h0);
        check({tag, "_mask"},  32'(mem_mask),  32'h0);
    endtask

    int exp_own [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int prev_own;
    int pulses;

    initial begin
        //           q0 w0 a0     d0            m0    q1 w1 a1     d1            m1     g0 g1 wen ren addr   wdata         mask   rv0 rv1 rdata
        vecs[0] = '{1, 0, 12'd5, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 0, 1, 12'd5, 32'h0,        4'h0,  0, 0, 32'h0};
        vecs[1] = '{0, 0, 12'd0, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  0, 0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 32'hA5A5_0001};
        vecs[2] = '{0, 0, 12'd0, 32'h0,        4'h0, 1, 1, 12'd9, 32'h1122_3344, 4'h5,  0, 1, 1, 0, 12'd9, 32'h1122_3344, 4'h5,  0, 0, 32'h0};
        vecs[3] = '{1, 0, 12'd9, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 0, 1, 12'd9, 32'h0,        4'h0,  0, 0, 32'h0};
        vecs[4] = '{0, 0, 12'd0, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  0, 0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 32'h0022_0044};
        vecs[5] = '{0, 0, 12'd0, 32'h0,        4'h0, 1, 0, 12'd5, 32'h0,        4'h0,  0, 1, 0, 1, 12'd5, 32'h0,        4'h0,  0, 0, 32'h0};
        vecs[6] = '{1, 1, 12'd5, 32'hFFFF_FFFF, 4'h8, 1, 0, 12'd9, 32'h0,        4'h0,  0, 1, 0, 1, 12'd9, 32'h0,        4'h0,  0, 1, 32'hA5A5_0001};
        vecs[7] = '{1, 1, 12'd5, 32'hFFFF_FFFF, 4'h8, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 1, 0, 12'd5, 32'hFFFF_FFFF, 4'h8,  0, 1, 32'h0022_0044};
        vecs[8] = '{1, 0, 12'd5, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 0, 1, 12'd5, 32'h0,        4'h0,  0, 0, 32'h0};
        vecs[9] = '{0, 0, 12'd0, 32'h0,        4'h0, 0, 0, 12'd0, 32'h0,        4'h0,  0, 0, 0, 0, 12'd0, 32'h0,        4'h0,  1, 0, 32'hFFA5_0001};

        rst = 1'b1;
        idle_inputs();
        // Reset state with requests pending: nothing may be granted.
        @(negedge clk);
        r0_req = 1; r1_req = 1; r0_we = 1; r0_wdata = 32'h1234_5678; r0_mask = 4'hF;
        #1;
        check("rst_g0", 32'(r0_gnt), 32'h0);
        check("rst_g1", 32'(r1_gnt), 32'h0);
        check("rst_rv0", 32'(r0_rvalid), 32'h0);
        check("rst_rv1", 32'(r1_rvalid), 32'h0);
        check_mem_idle("rst");
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // Vector table: single reads, masked write then read-after-write, contention.
        for (int i = 0; i < 10; i++) begin
            r0_req = vecs[i].q0; r0_we = vecs[i].w0; r0_addr = vecs[i].a0;
            r0_wdata = vecs[i].d0; r0_mask = vecs[i].m0;
            r1_req = vecs[i].q1; r1_we = vecs[i].w1; r1_addr = vecs[i].a1;
            r1_wdata = vecs[i].d1; r1_mask = vecs[i].m1;
            #1;
            check($sformatf("v%0d_g0", i),    32'(r0_gnt),    32'(vecs[i].e_g0));
            check($sformatf("v%0d_g1", i),    32'(r1_gnt),    32'(vecs[i].e_g1));
            check($sformatf("v%0d_wen", i),   32'(mem_wen),   32'(vecs[i].e_wen));
            check($sformatf("v%0d_ren", i),   32'(mem_ren),   32'(vecs[i].e_ren));
            check($sformatf("v%0d_waddr", i), 32'(mem_waddr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_raddr", i), 32'(mem_raddr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_wdata", i), mem_wdata,      vecs[i].e_wdata);
            check($sformatf("v%0d_mask", i),  32'(mem_mask),  32'(vecs[i].e_mask));
            check($sformatf("v%0d_rv0", i),   32'(r0_rvalid), 32'(vecs[i].e_rv0));
            check($sformatf("v%0d_rv1", i),   32'(r1_rvalid), 32'(vecs[i].e_rv1));
            if (vecs[i].e_rv0) check($sformatf("v%0d_rd0", i), r0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rv1) check($sformatf("v%0d_rd1", i), r1_rdata, vecs[i].e_rdata);
            @(negedge clk);
        end

        // Both ports reading continuously from reset: bursts of four, port 0 first.
        reset_dut();
        r0_req = 1; r0_addr = 12'd0;
        r1_req = 1; r1_addr = 12'd1;
        prev_own = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("burst%0d_g0", i), 32'(r0_gnt), 32'(exp_own[i] == 0));
            check($sformatf("burst%0d_g1", i), 32'(r1_gnt), 32'(exp_own[i] == 1));
            check($sformatf("burst%0d_raddr", i), 32'(mem_raddr), 32'(exp_own[i]));
            check($sformatf("burst%0d_rv0", i), 32'(r0_rvalid), 32'(prev_own == 0));
            check($sformatf("burst%0d_rv1", i), 32'(r1_rvalid), 32'(prev_own == 1));
            prev_own = exp_own[i];
            @(negedge clk);
        end
        idle_inputs();

        // Port 0 streams reads alone, then port 1 arrives with the burst saturated.
        reset_dut();
        pulses = 0;
        for (int i = 0; i <= 10; i++) begin
            r0_req = 1; r0_addr = 12'(i);
            if (i == 10) r1_req = 1;
            #1;
            if (i > 0 && r0_rvalid) pulses++;
            check($sformatf("strm%0d_rv1", i), 32'(r1_rvalid), 32'h0);
            if (i < 10) begin
                check($sformatf("strm%0d_g0", i), 32'(r0_gnt), 32'h1);
            end else begin
                check("strm_late_g1", 32'(r1_gnt), 32'h1);
                check("strm_late_g0", 32'(r0_gnt), 32'h0);
            end
            @(negedge clk);
        end
        check("strm_pulses", 32'(pulses), 32'd10);
        idle_inputs();

        // Reset pulsed the cycle after a read grant: the response is dropped.
        reset_dut();
        @(negedge clk);
        r0_req = 1; r0_addr = 12'd5;
        #1;
        check("rr_g0", 32'(r0_gnt), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1; r0_we = 1; r0_wdata = 32'hDEAD_BEEF; r0_mask = 4'hF; r0_addr = 12'd7;
        r1_req = 1; r1_addr = 12'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("rr_in%0d_rv0", i), 32'(r0_rvalid), 32'h0);
            check($sformatf("rr_in%0d_rv1", i), 32'(r1_rvalid), 32'h0);
            check($sformatf("rr_in%0d_g0", i),  32'(r0_gnt),    32'h0);
            check($sformatf("rr_in%0d_g1", i),  32'(r1_gnt),    32'h0);
            check_mem_idle($sformatf("rr_in%0d", i));
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("rr_post_rv0", 32'(r0_rvalid), 32'h0);
        check("rr_post_rv1", 32'(r1_rvalid), 32'h0);
        check("rr_tie_g0", 32'(r0_gnt), 32'h1);
        check("rr_tie_g1", 32'(r1_gnt), 32'h0);
        check("rr_tie_wen", 32'(mem_wen), 32'h1);
        check("rr_tie_waddr", 32'(mem_waddr), 32'd7);
        @(negedge clk);
        check("rr_post2_rv0", 32'(r0_rvalid), 32'h0);
        check("rr_post2_rv1", 32'(r1_rvalid), 32'h0);
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    // Grant exclusivity and read/write exclusivity must hold on every cycle.
    always @(negedge clk) begin
        if (r0_gnt && r1_gnt) begin
            n_fail++;
            $display("FAIL dual_gnt: got both grants expected at most one at %0t", $time);
        end
        if (mem_wen && mem_ren) begin
            n_fail++;
            $display("FAIL wen_ren: got both enables expected at most one at %0t", $time);
        end
    end

endmodule
